latch_bank_loader: RTL

Upstream sequencer that feeds a bank of enable-gated D latches with synchronous reset. It assembles a serial bit stream into a WIDTH-bit word under a valid/ready handshake. It then drives the latch bank's data, enable and reset lines with guaranteed setup and hold framing around the enable window. It also provides a clear command that pulses the latch bank's enable and reset together.

---
 rtl/latch_bank_loader.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/latch_bank_loader.sv
// Serial-to-parallel loader that frames writes and clears for a bank of enable-gated latches.
// Optional even-parity check on each word is compiled in when PARITY_CHECK_EN is defined.
module latch_bank_loader #(
  parameter int WIDTH     = 8,
  parameter int EN_CYCLES = 2,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  input  logic             s_bit,
  output logic             s_ready,
  input  logic             clr_req,
  output logic [WIDTH-1:0] lat_d,
  output logic             lat_en,
  output logic             lat_rst,
  output logic             busy,
  output logic             done,
  output logic             err
);

`ifdef PARITY_CHECK_EN
  localparam int NBITS = WIDTH + 1;
`else
  localparam int NBITS = WIDTH;
`endif
  localparam int CW = $clog2(NBITS + 1);
  localparam int EW = $clog2(EN_CYCLES + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(NBITS - 1);
  localparam logic [EW-1:0] EN_LAST  = EW'(EN_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SHIFT  = 3'd1,
    ST_SETUP  = 3'd2,
    ST_ENABLE = 3'd3,
    ST_CLEAR  = 3'd4,
    ST_HOLD   = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [EW-1:0]    cyc_q, cyc_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic [WIDTH-1:0] lat_d_q, lat_d_d;
  logic             lat_en_q, lat_rst_q, busy_q, done_q, err_q;
  logic             err_d;
  logic             accept_s;
  logic [WIDTH-1:0] shifted_s;

  // Ready only while collecting bits; a pending clear blocks acceptance.
  assign s_ready  = ((state_q == ST_IDLE) || (state_q == ST_SHIFT)) && !clr_req;
  assign accept_s = s_valid && s_ready;

  generate
    if (WIDTH == 1) begin : g_w1
      assign shifted_s = s_bit;
    end else if (MSB_FIRST != 0) begin : g_msb
      assign shifted_s = {word_q[WIDTH-2:0], s_bit};
    end else begin : g_lsb
      assign shifted_s = {s_bit, word_q[WIDTH-1:1]};
    end
  endgenerate

  // Next-state, bit assembly and latch data selection.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cyc_d   = cyc_q;
    word_d  = word_q;
    lat_d_d = lat_d_q;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE, ST_SHIFT: begin
        if (clr_req) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
          cyc_d   = '0;
          lat_d_d = '0;
        end else if (accept_s) begin
          if (cnt_q == LAST_CNT) begin
            cnt_d = '0;
            cyc_d = '0;
`ifdef PARITY_CHECK_EN
            // The final bit is the parity bit and is not shifted into the word.
            if ((^word_q ^ s_bit) == 1'b0) begin
              state_d = ST_SETUP;
              lat_d_d = word_q;
            end else begin
              state_d = ST_IDLE;
              err_d   = 1'b1;
            end
`else
            word_d  = shifted_s;
            lat_d_d = shifted_s;
            state_d = ST_SETUP;
`endif
          end else begin
            word_d  = shifted_s;
            cnt_d   = cnt_q + 1'b1;
            state_d = ST_SHIFT;
          end
        end else begin
          state_d = state_q;
        end
      end
      ST_SETUP: begin
        state_d = ST_ENABLE;
        cyc_d   = '0;
      end
      ST_ENABLE, ST_CLEAR: begin
        if (cyc_q == EN_LAST) begin
          state_d = ST_HOLD;
          cyc_d   = '0;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      ST_HOLD: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        cyc_d   = '0;
      end
    endcase
  end

  // State and registered outputs; outputs are decoded from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      cyc_q     <= '0;
      word_q    <= '0;
      lat_d_q   <= '0;
      lat_en_q  <= 1'b0;
      lat_rst_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cyc_q     <= cyc_d;
      word_q    <= word_d;
      lat_d_q   <= lat_d_d;
      lat_en_q  <= (state_d == ST_ENABLE) || (state_d == ST_CLEAR);
      lat_rst_q <= (state_d == ST_CLEAR);
      busy_q    <= (state_d != ST_IDLE);
      done_q    <= (state_d == ST_HOLD);
      err_q     <= err_d;
    end
  end

  assign lat_d   = lat_d_q;
  assign lat_en  = lat_en_q;
  assign lat_rst = lat_rst_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;

endmodule
